eth_fcs_engine: RTL and testbench

Parametrised Ethernet FCS engine for the 1G SFP datapath: a byte stream passes through with valid/ready flow control on both sides, and the CRC-32 is computed in line. In generate mode it pads runt frames with 0x00 up to a minimum length and appends the 4 FCS bytes. In check mode it passes frames through unchanged, flags each frame good or bad from the CRC residue, and keeps an error count. It sits between the TS packetiser/MAC framing logic and the GTX byte interface on transmit, and the mirror position on receive.

---
 rtl/eth_fcs_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_eth_fcs_engine.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_engine.sv
// eth_fcs_engine: in-line Ethernet CRC-32 engine with valid/ready on both sides.
// Generate mode pads runt frames with 0x00 up to MIN_LEN and appends the FCS.
// Check mode passes frames through unchanged and reports a per-frame verdict
// from the CRC residue, plus a saturating count of bad frames.
module eth_fcs_engine #(
    parameter bit          CHECK_MODE = 1'b0,
    parameter bit          PAD_EN     = 1'b1,
    parameter int unsigned MIN_LEN    = 60,
    parameter int unsigned ERRCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic                crc_valid,
    output logic                crc_ok,
    output logic [ERRCNT_W-1:0] crc_err_cnt
);

    localparam int          CNT_W     = 11;
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESID = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_PAD  = 2'd1,
        ST_FCS  = 2'd2
    } state_t;

    // One byte of reflected CRC-32, data LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [31:0]          crc_r, crc_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [1:0]           fcs_idx_r, fcs_idx_nxt_s;
    logic [7:0]           out_data_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic                 crc_valid_r;
    logic                 crc_ok_r;
    logic [ERRCNT_W-1:0]  err_cnt_r;

    logic                 slot_free_s;
    logic                 in_ready_s;
    logic                 load_s;
    logic [7:0]           load_data_s;
    logic                 load_last_s;
    logic                 frame_end_s;
    logic [31:0]          crc_in_s;
    logic [31:0]          crc_pad_s;
    logic [31:0]          fcs_s;
    logic [CNT_W-1:0]     cnt_plus1_s;
    logic [CNT_W-1:0]     cnt_sat_s;

    assign slot_free_s = ~out_valid_r | out_ready;
    assign crc_in_s    = crc32_byte(crc_r, in_data);
    assign crc_pad_s   = crc32_byte(crc_r, 8'h00);
    assign fcs_s       = ~crc_r;
    assign cnt_plus1_s = cnt_r + 11'd1;
    assign cnt_sat_s   = (cnt_r >= MIN_LEN_C) ? cnt_r : cnt_plus1_s;

    // Next-state, output-register load and CRC/counter update decisions.
    always_comb begin
        state_nxt_s   = state_r;
        crc_nxt_s     = crc_r;
        cnt_nxt_s     = cnt_r;
        fcs_idx_nxt_s = fcs_idx_r;
        in_ready_s    = 1'b0;
        load_s        = 1'b0;
        load_data_s   = 8'h00;
        load_last_s   = 1'b0;
        frame_end_s   = 1'b0;
        case (state_r)
            ST_DATA: begin
                in_ready_s = rst_n & slot_free_s;
                if (in_valid && in_ready_s) begin
                    load_s      = 1'b1;
                    load_data_s = in_data;
                    crc_nxt_s   = crc_in_s;
                    cnt_nxt_s   = cnt_sat_s;
                    if (in_last) begin
                        if (CHECK_MODE) begin
                            // Verdict is taken from crc_in_s; restart for the next frame.
                            load_last_s = 1'b1;
                            frame_end_s = 1'b1;
                            crc_nxt_s   = CRC_INIT;
                            cnt_nxt_s   = 11'd0;
                        end else begin
                            fcs_idx_nxt_s = 2'd0;
                            if (PAD_EN && (cnt_plus1_s < MIN_LEN_C)) begin
                                state_nxt_s = ST_PAD;
                            end else begin
                                state_nxt_s = ST_FCS;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAD: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_data_s = 8'h00;
                    crc_nxt_s   = crc_pad_s;
                    cnt_nxt_s   = cnt_sat_s;
                    if (cnt_plus1_s >= MIN_LEN_C) begin
                        state_nxt_s   = ST_FCS;
                        fcs_idx_nxt_s = 2'd0;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            ST_FCS: begin
                if (slot_free_s) begin
                    load_s = 1'b1;
                    case (fcs_idx_r)
                        2'd0:    load_data_s = fcs_s[7:0];
                        2'd1:    load_data_s = fcs_s[15:8];
                        2'd2:    load_data_s = fcs_s[23:16];
                        2'd3:    load_data_s = fcs_s[31:24];
                        default: load_data_s = 8'h00;
                    endcase
                    if (fcs_idx_r == 2'd3) begin
                        load_last_s   = 1'b1;
                        state_nxt_s   = ST_DATA;
                        crc_nxt_s     = CRC_INIT;
                        cnt_nxt_s     = 11'd0;
                        fcs_idx_nxt_s = 2'd0;
                    end else begin
                        fcs_idx_nxt_s = fcs_idx_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = ST_FCS;
                end
            end
            default: begin
                state_nxt_s = ST_DATA;
            end
        endcase
    end

    // Frame state, CRC accumulator and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_DATA;
            crc_r     <= CRC_INIT;
            cnt_r     <= 11'd0;
            fcs_idx_r <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            crc_r     <= crc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            fcs_idx_r <= fcs_idx_nxt_s;
        end
    end

    // Output byte register: load on a free slot, drain on handshake, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= load_data_s;
            out_valid_r <= 1'b1;
            out_last_r  <= load_last_s;
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Check-mode verdict pulse and saturating bad-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_valid_r <= 1'b0;
            crc_ok_r    <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            crc_valid_r <= frame_end_s;
            if (frame_end_s) begin
                crc_ok_r <= (crc_in_s == CRC_RESID);
                if ((crc_in_s != CRC_RESID) && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
                    err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                crc_ok_r <= crc_ok_r;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign crc_valid   = crc_valid_r;
    assign crc_ok      = crc_ok_r;
    assign crc_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_eth_fcs_engine.sv
// Self-checking bench for eth_fcs_engine: three instances (generate with pad,
// generate without pad, check mode with a 2-bit error counter) share the input
// stimulus; one is selected for observation per test.
module tb_eth_fcs_engine;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic [7:0] g_out_data, n_out_data, c_out_data;
    logic       g_out_valid, n_out_valid, c_out_valid;
    logic       g_out_last, n_out_last, c_out_last;
    logic       g_in_ready, n_in_ready, c_in_ready;
    logic       g_crc_valid, n_crc_valid, c_crc_valid;
    logic       g_crc_ok, n_crc_ok, c_crc_ok;
    logic [15:0] g_err_cnt, n_err_cnt;
    logic [1:0]  c_err_cnt;

    eth_fcs_engine #(.CHECK_MODE(1'b0), .PAD_EN(1'b1), .MIN_LEN(60), .ERRCNT_W(16)) u_gen (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(g_in_ready), .out_data(g_out_data), .out_valid(g_out_valid), .out_last(g_out_last),
        .out_ready(out_ready), .crc_valid(g_crc_valid), .crc_ok(g_crc_ok), .crc_err_cnt(g_err_cnt));

    eth_fcs_engine #(.CHECK_MODE(1'b0), .PAD_EN(1'b0), .MIN_LEN(60), .ERRCNT_W(16)) u_gnp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(n_in_ready), .out_data(n_out_data), .out_valid(n_out_valid), .out_last(n_out_last),
        .out_ready(out_ready), .crc_valid(n_crc_valid), .crc_ok(n_crc_ok), .crc_err_cnt(n_err_cnt));

    eth_fcs_engine #(.CHECK_MODE(1'b1), .PAD_EN(1'b0), .MIN_LEN(60), .ERRCNT_W(2)) u_chk (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
        .out_ready(out_ready), .crc_valid(c_crc_valid), .crc_ok(c_crc_ok), .crc_err_cnt(c_err_cnt));

    // Observed instance: 0 = u_gen, 1 = u_gnp, 2 = u_chk
    int         sel;
    logic [7:0] o_data;
    logic       o_valid, o_last, i_ready;

    always_comb begin
        o_data = g_out_data; o_valid = g_out_valid; o_last = g_out_last; i_ready = g_in_ready;
        if (sel == 1) begin
            o_data = n_out_data; o_valid = n_out_valid; o_last = n_out_last; i_ready = n_in_ready;
        end else if (sel == 2) begin
            o_data = c_out_data; o_valid = c_out_valid; o_last = c_out_last; i_ready = c_in_ready;
        end
    end

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: bit-serial reflected CRC-32 over message bits, LSB first
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [7:0] fr[$];
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] mon_d[$];
    bit         mon_l[$];
    int         mon_c[$];
    int         cyc;
    bit         rand_en;
    bit         stall_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: records handshaken bytes and checks hold-while-stalled
    initial begin
        logic [7:0] prev_d;
        bit prev_l, prev_stall;
        prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_en && prev_stall)
                check("stall_hold", {23'd0, o_valid, o_last, o_data}, {23'd0, 1'b1, prev_l, prev_d});
            if (o_valid && out_ready) begin
                mon_d.push_back(o_data); mon_l.push_back(o_last); mon_c.push_back(cyc);
            end
            prev_stall = o_valid && !out_ready;
            prev_d = o_data; prev_l = o_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        mon_d.delete(); mon_l.delete(); mon_c.delete(); exp_d.delete(); exp_l.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync();
        clear_q();
    endtask

    // Present one byte and hold it until the selected instance takes it
    task automatic drive_byte(input logic [7:0] b, input bit last);
        int t;
        in_valid = 1'b1; in_data = b; in_last = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (i_ready) break;
            t++;
            if (t > 2000) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) drive_byte(fr[i], i == fr.size() - 1);
    endtask

    task automatic expect_gen(input bit pad_en);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF; n = 0;
        foreach (fr[i]) begin
            exp_d.push_back(fr[i]); exp_l.push_back(1'b0); c = crc_step(c, fr[i]); n++;
        end
        while (pad_en && n < 60) begin
            exp_d.push_back(8'h00); exp_l.push_back(1'b0); c = crc_step(c, 8'h00); n++;
        end
        c = ~c;
        for (int j = 0; j < 4; j++) begin
            exp_d.push_back(c[8*j +: 8]); exp_l.push_back(j == 3);
        end
    endtask

    task automatic expect_pass();
        foreach (fr[i]) begin
            exp_d.push_back(fr[i]); exp_l.push_back(i == fr.size() - 1);
        end
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (mon_d.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_stream(input string name);
        int errs;
        errs = 0;
        check({name, "_len"}, mon_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < mon_d.size(); i++)
            if (mon_d[i] !== exp_d[i] || mon_l[i] !== exp_l[i]) errs++;
        check({name, "_bytes"}, errs, 0);
    endtask

    task automatic load_ascii();
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    endtask

    typedef struct {
        logic [7:0] last_b;
        logic       exp_ok;
        logic [1:0] exp_cnt;
    } chk_vec_t;
    chk_vec_t tbl[7];

    logic [7:0] kfcs[4];

    initial begin
        int t;
        bit seen;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        sel = 0; rand_en = 1'b0; stall_en = 1'b0;
        kfcs[0] = 8'h26; kfcs[1] = 8'h39; kfcs[2] = 8'hF4; kfcs[3] = 8'hCB;
        tbl[0] = '{8'hCB, 1'b1, 2'd0};
        tbl[1] = '{8'hCA, 1'b0, 2'd1};
        tbl[2] = '{8'hCA, 1'b0, 2'd2};
        tbl[3] = '{8'h00, 1'b0, 2'd3};
        tbl[4] = '{8'hCA, 1'b0, 2'd3};
        tbl[5] = '{8'hCB, 1'b1, 2'd3};
        tbl[6] = '{8'hFF, 1'b0, 2'd3};

        // Reset values while rst_n is low
        repeat (3) @(negedge clk);
        check("rst_out_valid", {29'd0, g_out_valid, n_out_valid, c_out_valid}, 32'd0);
        check("rst_out_last", {29'd0, g_out_last, n_out_last, c_out_last}, 32'd0);
        check("rst_out_data", {8'd0, g_out_data, n_out_data, c_out_data}, 32'd0);
        check("rst_in_ready", {29'd0, g_in_ready, n_in_ready, c_in_ready}, 32'd0);
        check("rst_crc", {28'd0, c_crc_valid, c_crc_ok, c_err_cnt}, 32'd0);
        rst_n = 1'b1;
        sync();

        // No padding: "123456789" -> 13 bytes, FCS 26 39 F4 CB, no gaps
        sel = 1;
        do_reset();
        load_ascii();
        send_frame();
        expect_gen(1'b0);
        wait_out(13);
        compare_stream("nopad_ascii");
        for (int j = 0; j < 4; j++) check("nopad_fcs_const", mon_d[9 + j], kfcs[j]);
        check("nopad_no_gaps", mon_c[12] - mon_c[0], 12);

        // 1-byte runt padded to 60, in_ready low through pad and FCS
        sel = 0;
        do_reset();
        fr.delete(); fr.push_back(8'hAA);
        send_frame();
        seen = 1'b0; t = 0;
        forever begin
            @(negedge clk);
            if (o_valid && o_last) break;
            if (i_ready) seen = 1'b1;
            t++;
            if (t > 200) break;
        end
        check("pad_in_ready_low", seen, 1'b0);
        check("pad_ready_on_fcs3", i_ready, 1'b1);
        expect_gen(1'b1);
        wait_out(64);
        check("pad_total_64", mon_d.size(), 64);
        compare_stream("pad_runt");

        // Random back-pressure, back-to-back 60 and 100 byte frames plus random lengths
        do_reset();
        rand_en = 1'b1; stall_en = 1'b1;
        fr.delete(); for (int i = 0; i < 60; i++) fr.push_back(8'($urandom));
        send_frame(); expect_gen(1'b1);
        fr.delete(); for (int i = 0; i < 100; i++) fr.push_back(8'($urandom));
        send_frame(); expect_gen(1'b1);
        for (int f = 0; f < 4; f++) begin
            fr.delete();
            for (int i = 0; i < $urandom_range(1, 80); i++) fr.push_back(8'($urandom));
            send_frame(); expect_gen(1'b1);
        end
        wait_out(exp_d.size());
        compare_stream("rand_stream");
        stall_en = 1'b0; rand_en = 1'b0;
        sync();
        out_ready = 1'b1;

        // Reset after 20 bytes of a 60-byte frame aborts it
        sel = 1;
        do_reset();
        fr.delete(); for (int i = 0; i < 60; i++) fr.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) drive_byte(fr[i], 1'b0);
        check("prerst_valid", o_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", o_valid, 1'b0);
        check("rstmid_in_ready", i_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (20) @(negedge clk);
        check("rstmid_no_fcs", mon_d.size(), 0);
        sync();
        load_ascii();
        send_frame();
        expect_gen(1'b0);
        wait_out(13);
        compare_stream("post_rst_ascii");
        for (int j = 0; j < 4; j++) check("post_rst_fcs", mon_d[mon_d.size() - 4 + j], kfcs[j]);

        // Check mode: table of frames with good/bad final byte, 2-bit saturating count
        sel = 2;
        do_reset();
        foreach (tbl[v]) begin
            load_ascii();
            fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4);
            fr.push_back(tbl[v].last_b);
            send_frame();
            expect_pass();
            @(negedge clk);
            check("chk_crc_valid", c_crc_valid, 1'b1);
            check("chk_out_last_with_verdict", {o_valid, o_last}, 2'b11);
            check("chk_crc_ok", c_crc_ok, tbl[v].exp_ok);
            check("chk_err_cnt", c_err_cnt, tbl[v].exp_cnt);
            @(negedge clk);
            check("chk_crc_valid_pulse", c_crc_valid, 1'b0);
            sync();
        end
        wait_out(exp_d.size());
        compare_stream("chk_passthrough");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
